axi_bus_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port among N_REQ in-core requesters (req 0 = IF fetch, req 1 = MEM load/store).

---
 rtl/axi_bus_arbiter_if.sv | 56 +++++
 rtl/axi_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bus_arbiter_if.sv
// axi_bus_arbiter_if
//   Bundles the requester-side handshake and the AXI4-Lite master port of
//   axi_bus_arbiter into one interface.
//   modport master : arbiter view (drives req_ready, rsp_*, AR/R/AW/W/B master outputs)
//   modport slave  : environment view (requesters plus the AXI slave)
interface axi_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;

  // AXI4-Lite side
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY
  );
endinterface

// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter
//   Shares one AXI4-Lite master port among N_REQ requesters (req 0 = IF fetch,
//   req 1 = MEM load/store). One outstanding transaction at a time; a
//   registered one-cycle rsp_valid pulse goes back to the owning requester.
// Ports
//   ACLK    clock, rising edge
//   ARESET  asynchronous active-high reset
//   bus     axi_bus_arbiter_if.master (requester handshake + AXI4-Lite master)
// Configuration
//   AXI_ARB_RR_EN  defined   : round-robin, last granted index gets lowest priority
//                  undefined : fixed priority, highest index wins
//
// state | meaning
// IDLE  | waiting for a request; req_ready may assert
// RADDR | ARVALID held until ARREADY
// RDATA | RREADY held until RVALID
// WREQ  | AWVALID / WVALID held until each handshakes
// WRESP | BREADY held until BVALID
module axi_bus_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               ACLK,
  input logic               ARESET,
  axi_bus_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WREQ  = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;

  logic              w_gnt_any;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [N_REQ-1:0]  w_grant;
  logic              w_idle;
  logic              w_aw_done;
  logic              w_w_done;

`ifdef AXI_ARB_RR_EN
  logic [IDX_W-1:0]  r_last;

  // Search from r_last+1 upward (modulo N_REQ); descending k lets the
  // nearest candidate overwrite the farther ones.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(r_last) + k) % N_REQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDX_W'((int'(r_last) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      r_last <= IDX_W'(N_REQ - 1);
    else if (w_idle && w_gnt_any)
      r_last <= w_gnt_idx;
  end
`else
  // Ascending scan: the highest valid index is written last and wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_grant = '0;
    if (w_gnt_any)
      w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_idle    = (r_state == IDLE);
  assign w_aw_done = !r_awvalid || bus.AWREADY;
  assign w_w_done  = !r_wvalid  || bus.WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_araddr    <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_owner <= w_gnt_idx;
            if (bus.req_we[w_gnt_idx]) begin
              r_awaddr  <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
              r_wdata   <= bus.req_wdata[w_gnt_idx*DATA_W +: DATA_W];
              r_wstrb   <= bus.req_wstrb[w_gnt_idx*STRB_W +: STRB_W];
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WREQ;
            end else begin
              r_araddr  <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
              r_arvalid <= 1'b1;
              r_state   <= RADDR;
            end
          end
        end
        RADDR: begin
          if (bus.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (bus.RVALID) begin
            r_rready             <= 1'b0;
            r_rsp_valid[r_owner] <= 1'b1;
            r_rdata              <= bus.RDATA;
            r_err                <= (bus.RRESP != 2'b00);
            r_state              <= IDLE;
          end
        end
        WREQ: begin
          if (bus.AWREADY) r_awvalid <= 1'b0;
          if (bus.WREADY)  r_wvalid  <= 1'b0;
          // AW and W may complete in either order or together.
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WRESP;
          end
        end
        WRESP: begin
          if (bus.BVALID) begin
            r_bready             <= 1'b0;
            r_rsp_valid[r_owner] <= 1'b1;
            r_rdata              <= '0;
            r_err                <= (bus.BRESP != 2'b00);
            r_state              <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_grant & {N_REQ{w_idle}};
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.ARADDR    = r_araddr;
  assign bus.ARVALID   = r_arvalid;
  assign bus.RREADY    = r_rready;
  assign bus.AWADDR    = r_awaddr;
  assign bus.AWVALID   = r_awvalid;
  assign bus.WDATA     = r_wdata;
  assign bus.WSTRB     = r_wstrb;
  assign bus.WVALID    = r_wvalid;
  assign bus.BREADY    = r_bready;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
module tb_axi_bus_arbiter;
  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic ACLK = 1'b0;
  logic ARESET;

  axi_bus_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_bus_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  rsp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } sb_t;

  typedef struct {
    int          req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_resp;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_cyc = 0;
  int   rsp_cnt = 0;
  int   ar_hs = 0, aw_hs = 0, w_hs = 0;
  int   s_ar_dly = 0, s_r_dly = 0, s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // AXI slave: AR channel
  initial begin
    int cnt;
    cnt = 0;
    bus.ARREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (bus.ARVALID && !bus.ARREADY && !ARESET) begin
        if (cnt >= s_ar_dly) begin
          bus.ARREADY = 1'b1;
          cnt = 0;
          ar_hs++;
          if (sb_q.size() > 0) check("araddr", bus.ARADDR, sb_q[0].addr);
        end else cnt++;
      end else begin
        bus.ARREADY = 1'b0;
        if (!bus.ARVALID) cnt = 0;
      end
    end
  end

  // AXI slave: R channel
  initial begin
    int cnt;
    cnt = 0;
    bus.RVALID = 1'b0;
    bus.RDATA  = '0;
    bus.RRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (bus.RREADY && !bus.RVALID && !ARESET) begin
        if (cnt >= s_r_dly) begin
          bus.RVALID = 1'b1;
          bus.RDATA  = (sb_q.size() > 0) ? sb_q[0].slv_rdata : 32'h0;
          bus.RRESP  = (sb_q.size() > 0) ? sb_q[0].slv_resp : 2'b00;
          cnt = 0;
        end else cnt++;
      end else begin
        bus.RVALID = 1'b0;
        if (!bus.RREADY) cnt = 0;
      end
    end
  end

  // AXI slave: AW channel
  initial begin
    int cnt;
    cnt = 0;
    bus.AWREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (bus.AWVALID && !bus.AWREADY && !ARESET) begin
        if (cnt >= s_aw_dly) begin
          bus.AWREADY = 1'b1;
          cnt = 0;
          aw_hs++;
          if (sb_q.size() > 0) check("awaddr", bus.AWADDR, sb_q[0].addr);
        end else cnt++;
      end else begin
        bus.AWREADY = 1'b0;
        if (!bus.AWVALID) cnt = 0;
      end
    end
  end

  // AXI slave: W channel
  initial begin
    int cnt;
    cnt = 0;
    bus.WREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (bus.WVALID && !bus.WREADY && !ARESET) begin
        if (cnt >= s_w_dly) begin
          bus.WREADY = 1'b1;
          cnt = 0;
          w_hs++;
          if (sb_q.size() > 0) begin
            check("wdata", bus.WDATA, sb_q[0].wdata);
            check("wstrb", bus.WSTRB, sb_q[0].wstrb);
          end
        end else cnt++;
      end else begin
        bus.WREADY = 1'b0;
        if (!bus.WVALID) cnt = 0;
      end
    end
  end

  // AXI slave: B channel
  initial begin
    int cnt;
    cnt = 0;
    bus.BVALID = 1'b0;
    bus.BRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (bus.BREADY && !bus.BVALID && !ARESET) begin
        if (cnt >= s_b_dly) begin
          bus.BVALID = 1'b1;
          bus.BRESP  = (sb_q.size() > 0) ? sb_q[0].slv_resp : 2'b00;
          cnt = 0;
        end else cnt++;
      end else begin
        bus.BVALID = 1'b0;
        if (!bus.BREADY) cnt = 0;
      end
    end
  end

  // Response monitor / scoreboard consumer
  initial begin
    sb_t e;
    forever begin
      @(negedge ACLK);
      if (bus.rsp_valid != '0) begin
        rsp_cyc = cyc;
        rsp_cnt++;
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding (t=%0t)", bus.rsp_valid, $time);
        end else begin
          e = sb_q.pop_front();
          check("rsp_valid", bus.rsp_valid, e.rsp);
          check("rsp_rdata", bus.rsp_rdata, e.exp_rdata);
          check("rsp_err",   bus.rsp_err,   e.exp_err);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Drives one request, waits for its grant and releases req_valid.
  task automatic drive_req(input int req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, output int g_cyc);
    int t;
    @(negedge ACLK);
    bus.req_valid[req]          = 1'b1;
    bus.req_we[req]             = we;
    bus.req_addr[req*32 +: 32]  = addr;
    bus.req_wdata[req*32 +: 32] = wdata;
    bus.req_wstrb[req*4 +: 4]   = wstrb;
    #1;
    t = 0;
    while (!bus.req_ready[req] && t < 50) begin
      @(negedge ACLK);
      #1;
      t++;
    end
    check("grant", bus.req_ready[req], 1'b1);
    g_cyc = cyc;
    @(posedge ACLK);
    #1;
    bus.req_valid[req] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    int  ar0, aw0, w0, g_cyc;
    s_ar_dly = v.ar_dly; s_r_dly = v.r_dly;
    s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_b_dly = v.b_dly;
    e.rsp = v.exp_rsp; e.addr = v.addr; e.wdata = v.wdata; e.wstrb = v.wstrb;
    e.slv_rdata = v.slv_rdata; e.slv_resp = v.slv_resp;
    e.exp_rdata = v.exp_rdata; e.exp_err = v.exp_err;
    sb_q.push_back(e);
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    drive_req(v.req, v.we, v.addr, v.wdata, v.wstrb, g_cyc);
    wait_drain("complete");
    if (!v.we && v.ar_dly == 0 && v.r_dly == 0)
      check("read_latency", rsp_cyc - g_cyc, 3);
    check("ar_handshakes", ar_hs - ar0, v.we ? 0 : 1);
    check("aw_handshakes", aw_hs - aw0, v.we ? 1 : 0);
    check("w_handshakes",  w_hs - w0,   v.we ? 1 : 0);
    check("rready_idle", bus.RREADY, 1'b0);
    check("bready_idle", bus.BREADY, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_order[4];
    int   n, t, g_cyc, rc0;
    sb_t  e;
    vec_t rv;

    //          req we    addr          wdata         wstrb  slv_rdata     resp  ar r aw w b  exp_rsp exp_rdata     err
    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,  32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0, 2'b01, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 32'h0,         2'd0, 0, 0, 0, 2, 0, 2'b10, 32'h0,         1'b0};
    vecs[2] = '{1, 1'b0, 32'h0000_0004, 32'h0,        4'h0,  32'hCAFE_F00D, 2'd2, 1, 2, 0, 0, 0, 2'b10, 32'hCAFE_F00D, 1'b1};
    vecs[3] = '{0, 1'b1, 32'h8000_0000, 32'hAABB_CCDD, 4'hF, 32'h0,         2'd3, 0, 0, 3, 0, 2, 2'b01, 32'h0,         1'b1};
    vecs[4] = '{0, 1'b1, 32'h0000_0003, 32'h0000_0055, 4'h0, 32'h0,         2'd0, 0, 0, 0, 0, 0, 2'b01, 32'h0,         1'b0};
    vecs[5] = '{1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,  32'h1357_9BDF, 2'd1, 0, 0, 0, 0, 0, 2'b10, 32'h1357_9BDF, 1'b1};
    vecs[6] = '{0, 1'b0, 32'h0000_0020, 32'h0,        4'h0,  32'h0000_0001, 2'd0, 0, 0, 1, 1, 0, 2'b01, 32'h0000_0001, 1'b0};

`ifdef AXI_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1};
`endif

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);

    check("rst_arvalid",   bus.ARVALID,   1'b0);
    check("rst_awvalid",   bus.AWVALID,   1'b0);
    check("rst_wvalid",    bus.WVALID,    1'b0);
    check("rst_rready",    bus.RREADY,    1'b0);
    check("rst_bready",    bus.BREADY,    1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",   bus.rsp_err,   1'b0);
    check("rst_araddr",    bus.ARADDR,    32'h0);
    check("rst_awaddr",    bus.AWADDR,    32'h0);
    check("rst_wdata",     bus.WDATA,     32'h0);
    check("rst_wstrb",     bus.WSTRB,     4'h0);

    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check("idle_req_ready", bus.req_ready, 2'b00);
    check("idle_arvalid",   bus.ARVALID,   1'b0);
    check("idle_awvalid",   bus.AWVALID,   1'b0);

    // Contention straight out of reset: both requesters read continuously.
    s_ar_dly = 0; s_r_dly = 0; s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0;
    for (int i = 0; i < 4; i++) begin
      e.rsp       = 2'b01 << exp_order[i];
      e.addr      = (exp_order[i] == 1) ? 32'h0000_0300 : 32'h0000_0200;
      e.wdata     = '0;
      e.wstrb     = '0;
      e.slv_rdata = 32'hA000_0000 + 32'(i);
      e.slv_resp  = 2'b00;
      e.exp_rdata = 32'hA000_0000 + 32'(i);
      e.exp_err   = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge ACLK);
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h0000_0300, 32'h0000_0200};
    bus.req_valid = 2'b11;
    n = 0;
    t = 0;
    #1;
    while (n < 4 && t < 200) begin
      if (bus.req_ready != '0) begin
        check("arb_onehot", $countones(bus.req_ready), 1);
        check("arb_order",  bus.req_ready, 2'b01 << exp_order[n]);
        n++;
        if (n == 4) begin
          @(posedge ACLK);
          #1;
          bus.req_valid = 2'b00;
        end
      end
      @(negedge ACLK);
      #1;
      t++;
    end
    bus.req_valid = 2'b00;
    check("arb_grants", n, 4);
    wait_drain("arb_complete");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting in RDATA with the read data never arriving.
    s_ar_dly = 0; s_r_dly = 1000;
    rc0 = rsp_cnt;
    drive_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, g_cyc);
    t = 0;
    while (!bus.RREADY && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    check("mid_rready",  bus.RREADY,  1'b1);
    check("mid_arvalid", bus.ARVALID, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check("arst_rready",  bus.RREADY,    1'b0);
    check("arst_arvalid", bus.ARVALID,   1'b0);
    check("arst_araddr",  bus.ARADDR,    32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);
    check("arst_no_rsp", rsp_cnt - rc0, 0);

    rv = '{0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0BAD_F00D, 2'd0, 0, 0, 0, 0, 0, 2'b01, 32'h0BAD_F00D, 1'b0};
    run_vec(rv);

    repeat (3) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
